// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the command-master FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } cmd_state_e;

endpackage

// File: rtl/axi4lite_cmd_master.sv
// AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Single transaction in flight; every output is a flop.
module axi4lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic            m00_axi_aclk,
  input  logic            m00_axi_aresetn,
  // command interface
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  // response interface
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_write,
  output logic [AW-1:0]   rsp_addr,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            busy,
  // AXI4-Lite write address
  output logic [AW-1:0]   m00_axi_awaddr,
  output logic [2:0]      m00_axi_awprot,
  output logic            m00_axi_awvalid,
  input  logic            m00_axi_awready,
  // AXI4-Lite write data
  output logic [DW-1:0]   m00_axi_wdata,
  output logic [DW/8-1:0] m00_axi_wstrb,
  output logic            m00_axi_wvalid,
  input  logic            m00_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]      m00_axi_bresp,
  input  logic            m00_axi_bvalid,
  output logic            m00_axi_bready,
  // AXI4-Lite read address
  output logic [AW-1:0]   m00_axi_araddr,
  output logic [2:0]      m00_axi_arprot,
  output logic            m00_axi_arvalid,
  input  logic            m00_axi_arready,
  // AXI4-Lite read data
  input  logic [DW-1:0]   m00_axi_rdata,
  input  logic [1:0]      m00_axi_rresp,
  input  logic            m00_axi_rvalid,
  output logic            m00_axi_rready
);

  cmd_state_e state_q, state_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;

  logic            cmd_ready_d;
  logic            rsp_valid_d;
  logic            rsp_write_d;
  logic [AW-1:0]   rsp_addr_d;
  logic [DW-1:0]   rsp_rdata_d;
  logic [1:0]      rsp_resp_d;
  logic            busy_d;
  logic [AW-1:0]   awaddr_d;
  logic            awvalid_d;
  logic [DW-1:0]   wdata_d;
  logic [DW/8-1:0] wstrb_d;
  logic            wvalid_d;
  logic            bready_d;
  logic [AW-1:0]   araddr_d;
  logic            arvalid_d;
  logic            rready_d;

  // Protection attributes are never used by this master.
  assign m00_axi_awprot = '0;
  assign m00_axi_arprot = '0;

  // Next-state and next-output decode; every output is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_write_d = rsp_write;
    rsp_addr_d  = rsp_addr;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    awaddr_d    = m00_axi_awaddr;
    awvalid_d   = m00_axi_awvalid;
    wdata_d     = m00_axi_wdata;
    wstrb_d     = m00_axi_wstrb;
    wvalid_d    = m00_axi_wvalid;
    bready_d    = m00_axi_bready;
    araddr_d    = m00_axi_araddr;
    arvalid_d   = m00_axi_arvalid;
    rready_d    = m00_axi_rready;

    unique case (state_q)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          cmd_ready_d = 1'b0;
          rsp_write_d = cmd_write;
          rsp_addr_d  = cmd_addr;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW_W;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end else begin
          // Raised on the first clock after reset release.
          cmd_ready_d = 1'b1;
        end
      end
      WR_AW_W: begin
        if (m00_axi_awvalid && m00_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (m00_axi_wvalid && m00_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (m00_axi_bvalid && m00_axi_bready) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m00_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_AR: begin
        if (m00_axi_arvalid && m00_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m00_axi_rvalid && m00_axi_rready) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m00_axi_rdata;
          rsp_resp_d  = m00_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // busy is registered from the next state so it lines up with state_q.
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight command silently.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q         <= IDLE;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_addr        <= '0;
      rsp_rdata       <= '0;
      rsp_resp        <= '0;
      busy            <= 1'b0;
      m00_axi_awaddr  <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= '0;
      m00_axi_wstrb   <= '0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
    end else begin
      state_q         <= state_d;
      aw_done_q       <= aw_done_d;
      w_done_q        <= w_done_d;
      cmd_ready       <= cmd_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_write       <= rsp_write_d;
      rsp_addr        <= rsp_addr_d;
      rsp_rdata       <= rsp_rdata_d;
      rsp_resp        <= rsp_resp_d;
      busy            <= busy_d;
      m00_axi_awaddr  <= awaddr_d;
      m00_axi_awvalid <= awvalid_d;
      m00_axi_wdata   <= wdata_d;
      m00_axi_wstrb   <= wstrb_d;
      m00_axi_wvalid  <= wvalid_d;
      m00_axi_bready  <= bready_d;
      m00_axi_araddr  <= araddr_d;
      m00_axi_arvalid <= arvalid_d;
      m00_axi_rready  <= rready_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master against a small AXI4-Lite register-slave model.
module tb_axi4lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write, busy;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi4lite_cmd_master #(.DW(DW), .AW(AW)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  // ---------------- slave model ----------------
  int unsigned aw_dly = 0, w_dly = 0, ar_dly = 0;
  int unsigned aw_cnt, w_cnt, ar_cnt;
  logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
  logic        r_stall = 1'b0;
  logic [31:0] mem [4];
  logic        got_aw, got_w, r_pend;
  logic [3:0]  sl_awaddr, sl_araddr, sl_wstrb;
  logic [31:0] sl_wdata;

  assign awready = (aw_cnt >= aw_dly);
  assign wready  = (w_cnt >= w_dly);
  assign arready = (ar_cnt >= ar_dly);

  wire        aw_hs = awvalid && awready;
  wire        w_hs  = wvalid && wready;
  wire        ar_hs = arvalid && arready;
  wire [3:0]  wr_a  = aw_hs ? awaddr : sl_awaddr;
  wire [31:0] wr_d  = w_hs ? wdata : sl_wdata;
  wire [3:0]  wr_s  = w_hs ? wstrb : sl_wstrb;
  wire [3:0]  rd_a  = ar_hs ? araddr : sl_araddr;

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      sl_awaddr <= '0; sl_araddr <= '0; sl_wstrb <= '0; sl_wdata <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_cnt <= 0; got_aw <= 1'b1; sl_awaddr <= awaddr; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_cnt <= 0; got_w <= 1'b1; sl_wdata <= wdata; sl_wstrb <= wstrb; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (ar_hs) begin ar_cnt <= 0; r_pend <= 1'b1; sl_araddr <= araddr; end
      else if (arvalid) ar_cnt <= ar_cnt + 1;

      if ((got_aw || aw_hs) && (got_w || w_hs) && !bvalid) begin
        for (int i = 0; i < 4; i++)
          if (wr_s[i]) mem[wr_a[3:2]][8*i +: 8] <= wr_d[8*i +: 8];
        bvalid <= 1'b1; bresp <= cfg_bresp;
        got_aw <= 1'b0; got_w <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;

      if ((r_pend || ar_hs) && !rvalid && !r_stall) begin
        rvalid <= 1'b1; rdata <= mem[rd_a[3:2]]; rresp <= cfg_rresp;
        r_pend <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  typedef struct packed {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;
  rsp_t exp_q[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every presented response must equal the oldest expected one.
  always @(negedge clk) begin
    if (aresetn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
      end else begin
        check("rsp_write", rsp_write, exp_q[0].w);
        check("rsp_addr",  rsp_addr,  exp_q[0].a);
        check("rsp_rdata", rsp_rdata, exp_q[0].d);
        check("rsp_resp",  rsp_resp,  exp_q[0].r);
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Handshake counters for the stall scenario.
  logic cnt_en = 1'b0;
  int aw_hi = 0, w_hi = 0, early_b = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (bready && (awvalid || wvalid)) early_b++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a command and returns just after the accepting edge (cycle N+1).
  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic push,
                      input logic [31:0] erd, input logic [1:0] eresp);
    rsp_t e;
    int n = 0;
    if (push) begin
      e.w = w; e.a = a; e.d = erd; e.r = eresp;
      exp_q.push_back(e);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < LIMIT) begin tick(); n++; end
    check("cmd_accept_in_time", (n < LIMIT), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < LIMIT) begin tick(); n++; end
    check("drain_in_time", (n < LIMIT), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;

    // 1. reset for 4 clocks
    repeat (4) begin
      @(negedge clk);
      check("reset_outputs",
            {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready, busy}, 8'h00);
    end
    check("reset_addr_data", {awaddr, araddr, wdata, rsp_rdata}, 0);
    @(posedge clk); #2;
    aresetn = 1'b1;
    tick();
    check("cmd_ready_after_reset", cmd_ready, 1);

    // 2. single write, best-case latency
    send(1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, RESP_OKAY);
    check("aw_w_valid_n1", {awvalid, wvalid, busy, cmd_ready}, 4'b1110);
    check("aw_w_payload", {awaddr, wdata, wstrb}, {4'h0, 32'hDEADBEEF, 4'hF});
    tick();
    check("n2_state", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
    tick();
    check("rsp_valid_n3", rsp_valid, 1);
    drain();

    // 3. write then read back, responses in order
    send(1'b1, 4'h4, 32'h12345678, 4'hF, 1'b1, 32'h0, RESP_OKAY);
    send(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 32'h12345678, RESP_OKAY);
    check("ar_valid_n1", {arvalid, awvalid, wvalid}, 3'b100);
    send(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, RESP_OKAY);
    drain();

    // partial strobes
    send(1'b1, 4'h8, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h0, RESP_OKAY);
    send(1'b0, 4'h8, 32'h0, 4'h0, 1'b1, 32'h00BB00DD, RESP_OKAY);
    drain();

    // error responses pass through unchanged
    cfg_bresp = RESP_SLVERR;
    send(1'b1, 4'hC, 32'h11111111, 4'hF, 1'b1, 32'h0, RESP_SLVERR);
    drain();
    cfg_bresp = RESP_OKAY;
    cfg_rresp = RESP_DECERR;
    send(1'b0, 4'hC, 32'h0, 4'h0, 1'b1, 32'h11111111, RESP_DECERR);
    drain();
    cfg_rresp = RESP_OKAY;

    // 4. awready stalled, wready immediate
    aw_dly = 2;
    cnt_en = 1'b1;
    send(1'b1, 4'h4, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, RESP_OKAY);
    drain();
    cnt_en = 1'b0;
    check("stall_awvalid_cycles", aw_hi, 3);
    check("stall_wvalid_cycles", w_hi, 1);
    check("stall_bready_early", early_b, 0);
    aw_dly = 0;
    send(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, RESP_OKAY);
    drain();

    // 5. response back-pressure
    rsp_ready = 1'b0;
    send(1'b0, 4'h8, 32'h0, 4'h0, 1'b1, 32'h00BB00DD, RESP_OKAY);
    n = 0;
    while (!rsp_valid && n < LIMIT) begin tick(); n++; end
    check("rsp_valid_in_time", (n < LIMIT), 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    repeat (5) begin
      check("hold_cmd_ready_low", {cmd_ready, rsp_valid}, 2'b01);
      tick();
    end
    rsp_ready = 1'b1;
    send(1'b1, 4'h0, 32'h0BADF00D, 4'hF, 1'b1, 32'h0, RESP_OKAY);
    send(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 32'h0BADF00D, RESP_OKAY);
    drain();

    // 6. reset while waiting in RD_R
    r_stall = 1'b1;
    send(1'b0, 4'h8, 32'h0, 4'h0, 1'b0, 32'h0, RESP_OKAY);
    n = 0;
    while (!rready && n < LIMIT) begin tick(); n++; end
    check("rd_r_reached", (n < LIMIT), 1);
    tick();
    check("still_in_rd_r", {rready, busy, rsp_valid}, 3'b110);
    #1 aresetn = 1'b0;
    #1;
    check("async_reset_outputs", {rready, arvalid, busy, cmd_ready, rsp_valid}, 5'b00000);
    repeat (2) tick();
    check("no_rsp_after_reset", rsp_valid, 0);
    r_stall = 1'b0;
    aresetn = 1'b1;
    tick();
    check("cmd_ready_after_reset2", cmd_ready, 1);
    send(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 32'h0, RESP_OKAY);
    send(1'b1, 4'h4, 32'h5A5AA5A5, 4'hF, 1'b1, 32'h0, RESP_OKAY);
    send(1'b0, 4'h4, 32'h0, 4'h0, 1'b1, 32'h5A5AA5A5, RESP_OKAY);
    drain();
    repeat (3) tick();
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
